// File: rtl/calc1_pkg.sv
// rtl/calc1_pkg.sv - shared codes, state types and helpers for the calc1 port arbiter
//
// Purpose : command/response encodings, port and arbiter FSM state types,
//           and the command validity check used by the arbiter.
// Ports   : none (package).

package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        P_IDLE,
        P_OP2,
        P_PEND
    } port_state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_ISSUE,
        A_WAIT,
        A_RESP
    } arb_state_t;

    // Only commands the shared ALU actually implements; the no-op is never
    // captured, so it is not considered here.
    function automatic logic is_valid_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR: is_valid_cmd = 1'b1;
            default:                            is_valid_cmd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/calc1_port_arbiter_if.sv
// rtl/calc1_port_arbiter_if.sv - requester-port and ALU bus bundle for the calc1 port arbiter
//
// Purpose : groups the per-port request/response pins and the shared ALU
//           handshake into one bundle.
// Signals : req_cmd_in/req_data_in (per-port request), out_resp/out_data
//           (per-port response), alu_start/alu_cmd/alu_op1/alu_op2 (to ALU),
//           alu_done/alu_result/alu_err (from ALU).
// Modports: slave  - the arbiter block
//           master - the environment (requesters plus ALU)

interface calc1_port_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32
) ();

    logic [4*NUM_PORTS-1:0]      req_cmd_in;
    logic [DATA_W*NUM_PORTS-1:0] req_data_in;
    logic [2*NUM_PORTS-1:0]      out_resp;
    logic [DATA_W*NUM_PORTS-1:0] out_data;

    logic                        alu_start;
    logic [3:0]                  alu_cmd;
    logic [DATA_W-1:0]           alu_op1;
    logic [DATA_W-1:0]           alu_op2;
    logic                        alu_done;
    logic [DATA_W-1:0]           alu_result;
    logic                        alu_err;

    modport slave (
        input  req_cmd_in, req_data_in, alu_done, alu_result, alu_err,
        output out_resp, out_data, alu_start, alu_cmd, alu_op1, alu_op2
    );

    modport master (
        output req_cmd_in, req_data_in, alu_done, alu_result, alu_err,
        input  out_resp, out_data, alu_start, alu_cmd, alu_op1, alu_op2
    );

endinterface

// File: rtl/calc1_port_capture.sv
// rtl/calc1_port_capture.sv - per-port two-cycle request capture
//
// Purpose : captures cmd+op1 then op2 from one requester port and holds the
//           request pending until the arbiter has responded to it.
// Ports   : clk, rst_n        - clock, async active-low reset
//           cmd_in, data_in   - this port's request pins
//           clear             - arbiter is responding to this port this cycle
//           pending           - a complete request is waiting
//           cmd, op1, op2     - captured request

module calc1_port_capture
    import calc1_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        cmd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clear,
    output logic              pending,
    output logic [3:0]        cmd,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2
);

    port_state_t       state, state_n;
    logic [3:0]        cmd_n;
    logic [DATA_W-1:0] op1_n, op2_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= P_IDLE;
            cmd   <= '0;
            op1   <= '0;
            op2   <= '0;
        end else begin
            state <= state_n;
            cmd   <= cmd_n;
            op1   <= op1_n;
            op2   <= op2_n;
        end
    end

    always_comb begin
        state_n = state;
        cmd_n   = cmd;
        op1_n   = op1;
        op2_n   = op2;
        case (state)
            P_IDLE: begin
                if (cmd_in != CMD_NOP) begin
                    cmd_n   = cmd_in;
                    op1_n   = data_in;
                    state_n = P_OP2;
                end
            end
            P_OP2: begin
                op2_n   = data_in;
                state_n = P_PEND;
            end
            P_PEND: begin
                if (clear) begin
                    state_n = P_IDLE;
                end
            end
            default: state_n = P_IDLE;
        endcase
    end

    // Registered by construction: a port reaching PEND is visible to the
    // arbiter one cycle later.
    assign pending = (state == P_PEND);

endmodule

// File: rtl/calc1_port_arbiter.sv
// rtl/calc1_port_arbiter.sv - round-robin sharing of one calc1 ALU between requester ports
//
// Purpose : captures per-port requests, grants the ALU round-robin, waits
//           for the result (with a hang timeout) and returns the response to
//           the originating port for one cycle.
// Ports   : clk   - clock, rising edge
//           rst_n - async active-low reset
//           bus   - calc1_port_arbiter_if slave: request/response pins and
//                   the shared ALU handshake

module calc1_port_arbiter
    import calc1_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calc1_port_arbiter_if.slave  bus
);

    localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] port_clear;
    logic [3:0]           port_cmd [NUM_PORTS];
    logic [DATA_W-1:0]    port_op1 [NUM_PORTS];
    logic [DATA_W-1:0]    port_op2 [NUM_PORTS];

    arb_state_t        a_state, a_state_n;
    logic [PTR_W-1:0]  grant, grant_n;
    logic [PTR_W-1:0]  rr_ptr, rr_ptr_n;
    logic [TCNT_W-1:0] tcnt, tcnt_n;
    logic [1:0]        resp_code, resp_code_n;
    logic [DATA_W-1:0] resp_data, resp_data_n;
    logic [3:0]        alu_cmd_q, alu_cmd_n;
    logic [DATA_W-1:0] alu_op1_q, alu_op1_n;
    logic [DATA_W-1:0] alu_op2_q, alu_op2_n;

    logic [PTR_W-1:0]  sel;
    logic [PTR_W:0]    idx;
    logic              found;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign port_clear[p] = (a_state == A_RESP) && (grant == PTR_W'(p));

        calc1_port_capture #(.DATA_W(DATA_W)) u_capture (
            .clk     (clk),
            .rst_n   (rst_n),
            .cmd_in  (bus.req_cmd_in[4*p +: 4]),
            .data_in (bus.req_data_in[DATA_W*p +: DATA_W]),
            .clear   (port_clear[p]),
            .pending (pending[p]),
            .cmd     (port_cmd[p]),
            .op1     (port_op1[p]),
            .op2     (port_op2[p])
        );
    end

    // First pending port at or after rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_PORTS)) begin
                idx = idx - (PTR_W+1)'(NUM_PORTS);
            end
            if (!found && pending[idx[PTR_W-1:0]]) begin
                sel   = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state   <= A_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            tcnt      <= '0;
            resp_code <= RESP_NONE;
            resp_data <= '0;
            alu_cmd_q <= '0;
            alu_op1_q <= '0;
            alu_op2_q <= '0;
        end else begin
            a_state   <= a_state_n;
            grant     <= grant_n;
            rr_ptr    <= rr_ptr_n;
            tcnt      <= tcnt_n;
            resp_code <= resp_code_n;
            resp_data <= resp_data_n;
            alu_cmd_q <= alu_cmd_n;
            alu_op1_q <= alu_op1_n;
            alu_op2_q <= alu_op2_n;
        end
    end

    always_comb begin
        a_state_n   = a_state;
        grant_n     = grant;
        rr_ptr_n    = rr_ptr;
        tcnt_n      = tcnt;
        resp_code_n = resp_code;
        resp_data_n = resp_data;
        alu_cmd_n   = alu_cmd_q;
        alu_op1_n   = alu_op1_q;
        alu_op2_n   = alu_op2_q;
        case (a_state)
            A_IDLE: begin
                if (found) begin
                    grant_n   = sel;
                    alu_cmd_n = port_cmd[sel];
                    alu_op1_n = port_op1[sel];
                    alu_op2_n = port_op2[sel];
                    if (is_valid_cmd(port_cmd[sel])) begin
                        a_state_n = A_ISSUE;
                    end else begin
                        // Invalid commands never reach the ALU.
                        resp_code_n = RESP_ERR;
                        resp_data_n = '0;
                        a_state_n   = A_RESP;
                    end
                end
            end
            A_ISSUE: begin
                tcnt_n    = '0;
                a_state_n = A_WAIT;
            end
            A_WAIT: begin
                if (bus.alu_done) begin
                    resp_code_n = bus.alu_err ? RESP_ERR : RESP_OK;
                    resp_data_n = bus.alu_result;
                    tcnt_n      = '0;
                    a_state_n   = A_RESP;
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th cycle spent waiting: give up.
                    resp_code_n = RESP_ERR;
                    resp_data_n = '0;
                    tcnt_n      = '0;
                    a_state_n   = A_RESP;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            A_RESP: begin
                rr_ptr_n  = (grant == PTR_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
                a_state_n = A_IDLE;
            end
            default: a_state_n = A_IDLE;
        endcase
    end

    logic [2*NUM_PORTS-1:0]      resp_vec;
    logic [DATA_W*NUM_PORTS-1:0] data_vec;

    always_comb begin
        resp_vec = '0;
        data_vec = '0;
        if (a_state == A_RESP) begin
            resp_vec[2*int'(grant) +: 2]           = resp_code;
            data_vec[DATA_W*int'(grant) +: DATA_W] = resp_data;
        end
    end

    assign bus.out_resp  = resp_vec;
    assign bus.out_data  = data_vec;
    assign bus.alu_start = (a_state == A_ISSUE);
    assign bus.alu_cmd   = alu_cmd_q;
    assign bus.alu_op1   = alu_op1_q;
    assign bus.alu_op2   = alu_op2_q;

endmodule

// File: tb/tb_calc1_port_arbiter.sv
// tb/tb_calc1_port_arbiter.sv - scoreboard bench for calc1_port_arbiter

module tb_calc1_port_arbiter;
    import calc1_pkg::*;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int TO = 64;

    typedef struct {
        int          port;
        logic [1:0]  resp;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   unexp = 0;
    int   start_cnt = 0;
    int   hang = 0;
    exp_t sb[$];

    logic [3:0]  v_cmd [NP];
    logic [31:0] v_op1 [NP];
    logic [31:0] v_op2 [NP];

    calc1_port_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

    calc1_port_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int p, input logic [1:0] r, input logic [31:0] d, input int c);
        exp_t e;
        e.port = p; e.resp = r; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic set_req(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        v_cmd[p] = c; v_op1[p] = a; v_op2[p] = b;
    endtask

    // Called aligned to posedge+1; cmd/op1 in cycle t, op2 in cycle t+1.
    task automatic send(input logic [3:0] mask, output int t);
        t = cyc;
        for (int p = 0; p < NP; p++) if (mask[p]) begin
            bus.req_cmd_in[4*p +: 4]   = v_cmd[p];
            bus.req_data_in[32*p +: 32] = v_op1[p];
        end
        @(posedge clk); #1;
        for (int p = 0; p < NP; p++) if (mask[p]) begin
            bus.req_cmd_in[4*p +: 4]   = 4'd0;
            bus.req_data_in[32*p +: 32] = v_op2[p];
        end
        @(posedge clk); #1;
        bus.req_data_in = '0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_outstanding", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_out_resp"}, bus.out_resp, 0);
        chk({tag, "_out_data_any"}, |bus.out_data, 0);
        chk({tag, "_alu_start"}, bus.alu_start, 0);
        chk({tag, "_alu_cmd"}, bus.alu_cmd, 0);
        chk({tag, "_alu_op1"}, bus.alu_op1, 0);
        chk({tag, "_alu_op2"}, bus.alu_op2, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        bus.req_cmd_in = '0;
        bus.req_data_in = '0;
        #1;
        check_quiet("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ALU model: done one cycle after start, unless told to swallow starts.
    initial begin
        logic        pend;
        logic [32:0] wide;
        logic [31:0] res;
        logic        err;
        bus.alu_done = 1'b0;
        bus.alu_result = '0;
        bus.alu_err = 1'b0;
        forever begin
            @(negedge clk);
            pend = 1'b0; res = '0; err = 1'b0;
            if (bus.alu_start === 1'b1) begin
                start_cnt++;
                if (hang > 0) begin
                    hang--;
                end else begin
                    pend = 1'b1;
                    case (bus.alu_cmd)
                        4'd1: begin wide = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2}; res = wide[31:0]; err = wide[32]; end
                        4'd2: begin res = bus.alu_op1 - bus.alu_op2; err = (bus.alu_op1 < bus.alu_op2); end
                        4'd5: res = bus.alu_op1 << bus.alu_op2[4:0];
                        4'd6: res = bus.alu_op1 >> bus.alu_op2[4:0];
                        default: res = '0;
                    endcase
                end
            end
            @(posedge clk); #1;
            bus.alu_done = pend;
            bus.alu_result = res;
            bus.alu_err = err;
        end
    end

    // Monitor: pops the scoreboard whenever any port presents a response.
    initial begin
        int   nz;
        int   hit;
        int   others;
        exp_t e;
        forever begin
            @(negedge clk);
            nz = 0; hit = -1;
            for (int p = 0; p < NP; p++) begin
                if (bus.out_resp[2*p +: 2] != 2'd0) begin
                    nz++;
                    hit = p;
                end
            end
            if (nz > 1) chk("one_port_responds", nz, 1);
            if (nz >= 1) begin
                if (sb.size() == 0) begin
                    unexp++;
                    chk("unexpected_response_port", hit, -1);
                end else begin
                    e = sb.pop_front();
                    chk("resp_port", hit, e.port);
                    chk("resp_code", bus.out_resp[2*hit +: 2], e.resp);
                    chk("resp_data", bus.out_data[32*hit +: 32], e.data);
                    chk("resp_cycle", cyc, e.cyc);
                    others = 0;
                    for (int p = 0; p < NP; p++)
                        if (p != hit && bus.out_data[32*p +: 32] != 32'd0) others++;
                    chk("other_ports_data_zero", others, 0);
                end
            end
        end
    end

    initial begin
        int t;
        int s0;
        bus.req_cmd_in = '0;
        bus.req_data_in = '0;
        for (int p = 0; p < NP; p++) set_req(p, 4'd0, 32'd0, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check_quiet("por");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add on port 0: response at T+5.
        set_req(0, 4'd1, 32'd5, 32'd7);
        send(4'b0001, t);
        push(0, 2'd1, 32'd12, t + 5);
        drain(40);

        // All four ports at once from rr_ptr 0: one response per 4-cycle round.
        pulse_reset();
        for (int p = 0; p < NP; p++) set_req(p, 4'd1, 32'(10*p + 1), 32'(p + 2));
        send(4'b1111, t);
        push(0, 2'd1, 32'd3,  t + 5);
        push(1, 2'd1, 32'd14, t + 9);
        push(2, 2'd1, 32'd25, t + 13);
        push(3, 2'd1, 32'd36, t + 17);
        drain(60);

        // rr_ptr wrapped to 0 after port 3: port 0 wins the tie.
        set_req(3, 4'd1, 32'd100, 32'd1);
        set_req(0, 4'd1, 32'd200, 32'd2);
        send(4'b1001, t);
        push(0, 2'd1, 32'd202, t + 5);
        push(3, 2'd1, 32'd101, t + 9);
        drain(40);

        // Invalid command: error response straight from grant, no ALU start.
        s0 = start_cnt;
        set_req(2, 4'd3, 32'd55, 32'd66);
        send(4'b0100, t);
        push(2, 2'd2, 32'd0, t + 3);
        drain(40);
        chk("invalid_no_alu_start", start_cnt - s0, 0);

        // Add overflow flagged by the ALU.
        set_req(1, 4'd1, 32'hFFFF_FFFF, 32'd1);
        send(4'b0010, t);
        push(1, 2'd2, 32'd0, t + 5);
        drain(40);

        // Hung ALU on port 0 (rr_ptr=2 -> port 0 before port 1), then port 1 served.
        hang = 1;
        set_req(0, 4'd1, 32'd2, 32'd3);
        set_req(1, 4'd1, 32'd4, 32'd5);
        send(4'b0011, t);
        push(0, 2'd2, 32'd0, t + 4 + TO);
        push(1, 2'd1, 32'd9, t + 8 + TO);
        drain(200);

        // Subtract and shift right on other ports.
        set_req(3, 4'd2, 32'd10, 32'd3);
        send(4'b1000, t);
        push(3, 2'd1, 32'd7, t + 5);
        drain(40);
        set_req(2, 4'd6, 32'h8000_0000, 32'd4);
        send(4'b0100, t);
        push(2, 2'd1, 32'h0800_0000, t + 5);
        drain(40);

        // Shift-left sweep on port 0.
        for (int k = 0; k <= 30; k++) begin
            set_req(0, 4'd5, 32'd1, 32'(k));
            send(4'b0001, t);
            push(0, 2'd1, 32'd1 << k, t + 5);
            drain(40);
        end

        // Reset while the ALU is hung in WAIT: everything clears at once.
        hang = 1;
        set_req(2, 4'd1, 32'd1, 32'd1);
        send(4'b0100, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_quiet("midop_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hang = 0;
        s0 = unexp;
        repeat (TO + 16) @(posedge clk);
        #1;
        chk("no_stale_response", unexp - s0, 0);

        // Fresh request after reset keeps the T+5 latency.
        set_req(1, 4'd1, 32'd20, 32'd22);
        send(4'b0010, t);
        push(1, 2'd1, 32'd42, t + 5);
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/calc1_port_arbiter.md
Name: calc1_port_arbiter

Overview:
Shares one calc1 ALU datapath between NUM_PORTS requester ports. Each port issues a two-cycle request: cmd and operand1 in cycle 1, operand2 in cycle 2. The block captures each request, grants the ALU round-robin, and routes the result and response code back to the originating port. It sits between the calc1 port pins driven by the testbench and the single shared add/sub/shift unit.

Parameters:
NUM_PORTS, 4, number of requester ports (2..8)
DATA_W, 32, operand/result width
TIMEOUT, 64, max cycles in WAIT before the ALU is declared hung

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_cmd_in  in  4*NUM_PORTS  per-port command; slice p = [4p+3:4p]
req_data_in  in  DATA_W*NUM_PORTS  per-port operand (op1 in cmd cycle, op2 in next cycle)
out_resp  out  2*NUM_PORTS  per-port response: 0 none, 1 ok, 2 overflow/invalid/timeout
out_data  out  DATA_W*NUM_PORTS  per-port result, valid only while that port's out_resp != 0
alu_start  out  1  one-cycle pulse launching an operation
alu_cmd  out  4  command to ALU, held from start until done
alu_op1  out  DATA_W  operand1, held
alu_op2  out  DATA_W  operand2, held
alu_done  in  1  ALU result valid (one-cycle pulse)
alu_result  in  DATA_W  ALU result
alu_err  in  1  ALU overflow/underflow flag, qualified by alu_done

Behaviour:
- Reset (async, rst_n=0): all outputs 0. All port FSMs return to IDLE, arbiter to A_IDLE, rr pointer 0, timeout counter 0. Reset mid-operation discards all in-flight requests; no response is issued.
- Commands: 0 no-op, 1 add, 2 sub, 5 shl, 6 shr. All other nonzero codes are invalid.
- Per-port FSM:
  - IDLE: nonzero cmd -> latch cmd, op1 -> OP2.
  - OP2: latch data_in as op2 -> PEND. The cmd input is ignored in this cycle.
  - PEND: pending bit set; cmd inputs ignored. On response issued for this port -> IDLE.
  - A new command is accepted in IDLE in the cycle after the response cycle.
- Arbiter FSM:
  - A_IDLE: if any pending bit is set, grant the first pending port at or after rr_ptr (modulo NUM_PORTS). Load alu_cmd/op1/op2 from that port. Valid cmd -> ISSUE; invalid cmd -> RESP with code 2, data 0.
  - ISSUE: alu_start=1 for exactly one cycle -> WAIT. alu_done in ISSUE is ignored.
  - WAIT: on alu_done, capture result. Code is 2 if alu_err=1, else 1. -> RESP. The counter increments each cycle in WAIT; on reaching TIMEOUT -> RESP with code 2, data 0.
  - RESP: drive granted port's out_resp/out_data for exactly one cycle. Clear its pending bit. rr_ptr = grant+1 (wraps to 0). -> A_IDLE.
- Latency, uncontended, ALU done one cycle after start: cmd at T, op2 at T+1, grant at T+2, alu_start at T+3, alu_done at T+4, out_resp at T+5.
- out_resp/out_data of non-granted ports are 0 at all times. At most one port responds per cycle.
- Simultaneous events:
  - A port entering PEND in the same cycle the arbiter is in A_IDLE is seen the following cycle (pending is registered).
  - Ties are resolved solely by rr_ptr.
- alu_cmd/op1/op2 hold their value from grant until the next grant; they are 0 only after reset.
- Arithmetic is done in the ALU only. The block performs no width conversion; data passes through at DATA_W.

Decomposition:
- Package calc1_pkg:
  - command codes: CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR
  - response codes: RESP_NONE, RESP_OK, RESP_ERR
  - port FSM state typedef and arbiter state typedef
  - is_valid_cmd function
- One sub-module, calc1_port_capture, instantiated NUM_PORTS times. It holds the IDLE/OP2/PEND FSM, the cmd/op1/op2 registers and the pending flag.
- The top level holds the arbiter, rr pointer, timeout counter and response mux.

Test Plan:
- Single add: port0 cmd=1 data=5 at T, data=7 at T+1; ALU model returns 12 one cycle after start -> out_resp[1:0]=1, out_data[31:0]=12 at T+5; all other ports 0.
- Contention: ports 0..3 each issue add in the same cycle, rr_ptr=0 -> responses in order 0,1,2,3, one per arbitration round. Then port 3 and port 0 together -> port 0 first (rr_ptr wrapped to 0).
- Invalid/overflow: port2 cmd=3 -> out_resp=2, data=0, alu_start never pulses. Port1 add 0xFFFFFFFF+1 with ALU alu_err=1 -> out_resp=2.
- Timeout: ALU never asserts alu_done -> response code 2, data 0, exactly TIMEOUT cycles after entering WAIT. The next pending request is then served normally.
- Shift sweep: port0 shl with op1=1, op2=k for k=0..30 -> out_data = 1<<k on every iteration, resp 1.
- Reset mid-op: assert rst_n=0 during WAIT -> all outputs 0 immediately, no stale response after release. A fresh request completes with the T+5 latency.
